// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Used by pipeline_stall_controller (perf counters optional via PIPE_PERF_CNT_EN).
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LU    = 2'd1,
        ST_MEM   = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

endpackage

// File: rtl/pipe_perf_counters.sv
// Free-running event counters for the stall controller; each wraps modulo 2^PERF_W.
// Only instantiated when PIPE_PERF_CNT_EN is defined.
module pipe_perf_counters #(
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_evt,
    input  logic              flush_evt,
    input  logic              mem_wait_evt,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_count,
    output logic [PERF_W-1:0] mem_wait_cycles
);

    logic [PERF_W-1:0] stall_q, flush_q, mem_wait_q;
    logic [PERF_W-1:0] stall_d, flush_d, mem_wait_d;

    always_comb begin
        stall_d    = stall_q + PERF_W'(stall_evt);
        flush_d    = flush_q + PERF_W'(flush_evt);
        mem_wait_d = mem_wait_q + PERF_W'(mem_wait_evt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q    <= '0;
            flush_q    <= '0;
            mem_wait_q <= '0;
        end else begin
            stall_q    <= stall_d;
            flush_q    <= flush_d;
            mem_wait_q <= mem_wait_d;
        end
    end

    assign stall_cycles    = stall_q;
    assign flush_count     = flush_q;
    assign mem_wait_cycles = mem_wait_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer: MEM wait > redirect > load-use > run.
// Define PIPE_PERF_CNT_EN to add the stall/flush/mem-wait performance counters.
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
`ifdef PIPE_PERF_CNT_EN
    parameter int unsigned PERF_W      = 32,
`endif
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
`ifdef PIPE_PERF_CNT_EN
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_count,
    output logic [PERF_W-1:0] mem_wait_cycles,
`endif
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             mem_timeout,
    output logic [1:0]       state
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic             timeout_done_q, timeout_done_d;

    logic mem_wait, redirect, load_use, rs1_hit, rs2_hit;

    assign mem_wait = mem_req & ~mem_ready;
    assign redirect = ex_branch_taken & ~mem_wait;
    assign rs1_hit  = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit  = id_use_rs2 & (id_rs2 == ex_rd);
    // The ID instruction is killed by a redirect, so its dependency is moot.
    assign load_use = ex_mem_read & (ex_rd != '0) & (rs1_hit | rs2_hit)
                    & ~mem_wait & ~ex_branch_taken;

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (!rst_n) begin
            // Hold the pipeline empty while reset is asserted.
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (mem_wait) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (redirect) begin
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
        end else if (load_use) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_flush   = 1'b1;
        end
    end

    always_comb begin
        state_d = ST_RUN;
        if (mem_wait) begin
            state_d = ST_MEM;
        end else if (redirect) begin
            state_d = ST_FLUSH;
        end else if (load_use) begin
            state_d = ST_LU;
        end

        wait_cnt_d = '0;
        if (state_d == ST_MEM) begin
            wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end

        // Done flag keeps a saturated counter from re-firing within one episode.
        timeout_d      = (state_q == ST_MEM) && (wait_cnt_q == CNT_W'(MEM_TIMEOUT))
                       && !timeout_done_q;
        timeout_done_d = (state_d == ST_MEM) && (timeout_done_q || timeout_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= '0;
            timeout_q      <= 1'b0;
            timeout_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            timeout_q      <= timeout_d;
            timeout_done_q <= timeout_done_d;
        end
    end

    assign mem_timeout = timeout_q;
    assign state       = state_q;

`ifdef PIPE_PERF_CNT_EN
    pipe_perf_counters #(
        .PERF_W (PERF_W)
    ) u_perf (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_evt       (mem_wait | load_use),
        .flush_evt       (redirect),
        .mem_wait_evt    (mem_wait),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .mem_wait_cycles (mem_wait_cycles)
    );
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed-vector bench for pipeline_stall_controller (MEM_TIMEOUT = 3).
// Perf counter checks are compiled in only with PIPE_PERF_CNT_EN.
module tb_pipeline_stall_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ex_mem_read;
    logic [4:0] ex_rd, id_rs1, id_rs2;
    logic       id_use_rs1, id_use_rs2;
    logic       ex_branch_taken, mem_req, mem_ready;
    logic       pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic       if_id_flush, id_ex_flush, mem_wb_bubble;
    logic       mem_timeout;
    logic [1:0] state;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count, mem_wait_cycles;
`endif

    // {pc, if_id, id_ex, ex_mem write, if_id flush, id_ex flush, bubble}
    logic [6:0] ctl;
    assign ctl = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                  if_id_flush, id_ex_flush, mem_wb_bubble};

    localparam logic [6:0] CtlReset = 7'b0000_111;
    localparam logic [6:0] CtlRun   = 7'b1111_000;
    localparam logic [6:0] CtlLu    = 7'b0011_010;
    localparam logic [6:0] CtlRedir = 7'b1111_110;
    localparam logic [6:0] CtlMem   = 7'b0000_001;

    always #5 clk = ~clk;

    pipeline_stall_controller #(
        .CNT_W       (8),
        .MEM_TIMEOUT (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_write     (id_ex_write),
        .ex_mem_write    (ex_mem_write),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_bubble   (mem_wb_bubble),
        .mem_timeout     (mem_timeout),
        .state           (state)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .mem_wait_cycles (mem_wait_cycles)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ex_mem_read     = 1'b0;
        ex_rd           = 5'd0;
        id_rs1          = 5'd0;
        id_rs2          = 5'd0;
        id_use_rs1      = 1'b0;
        id_use_rs2      = 1'b0;
        ex_branch_taken = 1'b0;
        mem_req         = 1'b0;
        mem_ready       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic use1,
                          input logic [4:0] rs2, input logic use2);
        ex_mem_read = 1'b1;
        ex_rd       = rd;
        id_rs1      = rs1;
        id_use_rs1  = use1;
        id_rs2      = rs2;
        id_use_rs2  = use2;
    endtask

    int pulses;

    initial begin
        rst_n = 1'b0;
        idle();
        #3;
        check("reset_ctl", 32'(ctl), 32'(CtlReset));
        check("reset_state", 32'(state), 32'd0);
        check("reset_timeout", 32'(mem_timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("run_ctl", 32'(ctl), 32'(CtlRun));
        step();

        // Load-use via rs1
        set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        #1 check("lu_rs1_ctl", 32'(ctl), 32'(CtlLu));
        step();
        check("lu_state", 32'(state), 32'd1);
        idle();
        #1 check("lu_clear_ctl", 32'(ctl), 32'(CtlRun));
        step();
        check("lu_clear_state", 32'(state), 32'd0);

        // ex_rd == 0 and unused sources never stall; rs2 path does
        set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1 check("lu_rd0_ctl", 32'(ctl), 32'(CtlRun));
        set_lu(5'd9, 5'd9, 1'b0, 5'd9, 1'b0);
        #1 check("lu_nouse_ctl", 32'(ctl), 32'(CtlRun));
        set_lu(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
        #1 check("lu_rs2_ctl", 32'(ctl), 32'(CtlLu));
        ex_mem_read = 1'b0;
        #1 check("lu_noload_ctl", 32'(ctl), 32'(CtlRun));
        step();
        check("noload_state", 32'(state), 32'd0);

        // Redirect overrides load-use
        set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        ex_branch_taken = 1'b1;
        #1 check("redir_ctl", 32'(ctl), 32'(CtlRedir));
        step();
        check("redir_state", 32'(state), 32'd3);

        // MEM wait holds a pending branch for 4 cycles
        idle();
        ex_branch_taken = 1'b1;
        mem_req         = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("memhold_ctl", 32'(ctl), 32'(CtlMem));
            step();
            check("memhold_state", 32'(state), 32'd2);
        end
        mem_ready = 1'b1;
        #1 check("memdone_ctl", 32'(ctl), 32'(CtlRedir));
        step();
        check("memdone_state", 32'(state), 32'd3);
        idle();
        step();
        step();

        // 10-cycle wait: single timeout pulse 4 clocks after entry
        mem_req = 1'b1;
        pulses  = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (mem_timeout === 1'b1) pulses++;
            check("timeout_cycle", 32'(mem_timeout), (i == 4) ? 32'd1 : 32'd0);
        end
        check("timeout_total", 32'(pulses), 32'd1);
        idle();
        step();
        check("post_wait_state", 32'(state), 32'd0);

        // Async reset in the middle of a wait aborts it
        mem_req = 1'b1;
        step();
        step();
        step();
        #1 rst_n = 1'b0;
        #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_ctl", 32'(ctl), 32'(CtlReset));
        mem_req = 1'b0;
        #2 rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (mem_timeout !== 1'b0) pulses++;
        end
        check("midrst_no_timeout", 32'(pulses), 32'd0);

`ifdef PIPE_PERF_CNT_EN
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("perf_rst_stall", stall_cycles, 32'd0);
        check("perf_rst_flush", flush_count, 32'd0);
        check("perf_rst_mem", mem_wait_cycles, 32'd0);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            set_lu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
            step();
            idle();
            step();
        end
        mem_req = 1'b1;
        step();
        step();
        step();
        idle();
        ex_branch_taken = 1'b1;
        step();
        idle();
        step();
        check("perf_stall", stall_cycles, 32'd5);
        check("perf_mem", mem_wait_cycles, 32'd3);
        check("perf_flush", flush_count, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
